// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: instruction field layout, opcodes, tag width
// and the default reservation-station sizes.
package tomasulo_pkg;

    localparam int INSTR_W    = 16;
    localparam int TAG_W      = 3;
    localparam int REG_IDX_W  = 3;
    localparam int NUM_REGS   = 8;
    localparam int OP_W       = 4;
    localparam int OFF_W      = 3;

    localparam int OFF_LSB    = 13;
    localparam int RZ_LSB     = 10;
    localparam int RX_LSB     = 7;
    localparam int RY_LSB     = 4;
    localparam int OP_LSB     = 0;

    localparam int ADD_RS_DEF = 3;
    localparam int MUL_RS_DEF = 2;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL = 4'b0100;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ADD  = 2'd1,
        CLS_MUL  = 2'd2
    } rs_class_e;

    // Unknown opcodes map to CLS_NONE and are dropped by the issue stage.
    function automatic rs_class_e op_class(input logic [OP_W-1:0] op);
        rs_class_e cls;
        case (op)
            OP_ADD, OP_SUB: cls = CLS_ADD;
            OP_MUL:         cls = CLS_MUL;
            default:        cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/issue_unit_if.sv
// Instruction-queue / issue-unit / reservation-station handshake bundle.
interface issue_unit_if;
    import tomasulo_pkg::*;

    logic                 enableIn;
    logic [INSTR_W-1:0]   instructionIn;
    logic                 disponivel;
    logic                 issueValid;
    logic [TAG_W-1:0]     issueTag;
    logic [OP_W-1:0]      issueOp;
    logic [REG_IDX_W-1:0] issueRz;
    logic [TAG_W-1:0]     issueQj;
    logic [TAG_W-1:0]     issueQk;
    logic [OFF_W-1:0]     issueOffset;

    modport master (
        output enableIn, instructionIn,
        input  disponivel, issueValid, issueTag, issueOp, issueRz,
               issueQj, issueQk, issueOffset
    );

    modport slave (
        input  enableIn, instructionIn,
        output disponivel, issueValid, issueTag, issueOp, issueRz,
               issueQj, issueQk, issueOffset
    );

endinterface

// File: rtl/reg_status.sv
// Register-status table: per-register producing tag, CDB clear with
// same-cycle read bypass, dispatch write taking priority over CDB clear.
module reg_status
    import tomasulo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rx_i,
    input  logic [REG_IDX_W-1:0] ry_i,
    input  logic                 wr_en_i,
    input  logic [REG_IDX_W-1:0] wr_rz_i,
    input  logic [TAG_W-1:0]     wr_tag_i,
    input  logic                 cdb_valid_i,
    input  logic [TAG_W-1:0]     cdb_tag_i,
    output logic [TAG_W-1:0]     qj_o,
    output logic [TAG_W-1:0]     qk_o
);

    logic [TAG_W-1:0] status_q [NUM_REGS];
    logic [TAG_W-1:0] status_d [NUM_REGS];
    logic             cdb_hit_s;

    // Tag 0 means "ready", so a CDB broadcast of tag 0 must not touch anything.
    assign cdb_hit_s = cdb_valid_i && (cdb_tag_i != {TAG_W{1'b0}});

    // Reads see the pre-update table; a matching broadcast forces ready.
    assign qj_o = (cdb_hit_s && (status_q[rx_i] == cdb_tag_i)) ? {TAG_W{1'b0}} : status_q[rx_i];
    assign qk_o = (cdb_hit_s && (status_q[ry_i] == cdb_tag_i)) ? {TAG_W{1'b0}} : status_q[ry_i];

    // Next-state of each entry: dispatch write wins over CDB clear.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            status_d[i] = status_q[i];
            if (wr_en_i && (wr_rz_i == REG_IDX_W'(i))) begin
                status_d[i] = wr_tag_i;
            end else if (cdb_hit_s && (status_q[i] == cdb_tag_i)) begin
                status_d[i] = {TAG_W{1'b0}};
            end else begin
                status_d[i] = status_q[i];
            end
        end
    end

    // Status table storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                status_q[i] <= {TAG_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                status_q[i] <= status_d[i];
            end
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Tomasulo issue stage: one-deep holding register, RS-class selection,
// lowest-free-entry tag allocation and register-status lookup.
module issue_unit
    import tomasulo_pkg::*;
#(
    parameter int ADD_RS = ADD_RS_DEF,
    parameter int MUL_RS = MUL_RS_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    issue_unit_if.slave       bus,
    input  logic [ADD_RS-1:0] rsAddFree,
    input  logic [MUL_RS-1:0] rsMulFree,
    input  logic              cdbValid,
    input  logic [TAG_W-1:0]  cdbTag
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HELD  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    rs_class_e          cls_s;
    logic [TAG_W-1:0]   add_tag_s, mul_tag_s, issue_tag_s;
    logic               issue_valid_s;

    assign cls_s = op_class(instr_q[OP_LSB +: OP_W]);

    // Priority pick of the lowest-index free entry in each RS class.
    always_comb begin
        add_tag_s = {TAG_W{1'b0}};
        mul_tag_s = {TAG_W{1'b0}};
        for (int i = ADD_RS - 1; i >= 0; i--) begin
            if (rsAddFree[i]) begin
                add_tag_s = TAG_W'(i + 1);
            end else begin
                add_tag_s = add_tag_s;
            end
        end
        for (int i = MUL_RS - 1; i >= 0; i--) begin
            if (rsMulFree[i]) begin
                mul_tag_s = TAG_W'(ADD_RS + 1 + i);
            end else begin
                mul_tag_s = mul_tag_s;
            end
        end
    end

    // Dispatch decision for the held instruction.
    always_comb begin
        issue_valid_s = 1'b0;
        issue_tag_s   = {TAG_W{1'b0}};
        case (cls_s)
            CLS_ADD: begin
                issue_valid_s = (state_q == ST_HELD) && (|rsAddFree);
                issue_tag_s   = add_tag_s;
            end
            CLS_MUL: begin
                issue_valid_s = (state_q == ST_HELD) && (|rsMulFree);
                issue_tag_s   = mul_tag_s;
            end
            default: begin
                issue_valid_s = 1'b0;
                issue_tag_s   = {TAG_W{1'b0}};
            end
        endcase
    end

    // EMPTY/HELD sequencing; unknown opcodes leave HELD without dispatching.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            ST_EMPTY: begin
                if (bus.enableIn) begin
                    state_d = ST_HELD;
                    instr_d = bus.instructionIn;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_HELD: begin
                if (issue_valid_s || (cls_s == CLS_NONE)) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_HELD;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and holding register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_EMPTY;
            instr_q <= {INSTR_W{1'b0}};
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    reg_status u_reg_status (
        .clk         (Clock),
        .rst         (Reset),
        .rx_i        (instr_q[RX_LSB +: REG_IDX_W]),
        .ry_i        (instr_q[RY_LSB +: REG_IDX_W]),
        .wr_en_i     (issue_valid_s),
        .wr_rz_i     (instr_q[RZ_LSB +: REG_IDX_W]),
        .wr_tag_i    (issue_tag_s),
        .cdb_valid_i (cdbValid),
        .cdb_tag_i   (cdbTag),
        .qj_o        (bus.issueQj),
        .qk_o        (bus.issueQk)
    );

    assign bus.disponivel  = (state_q == ST_EMPTY);
    assign bus.issueValid  = issue_valid_s;
    assign bus.issueTag    = issue_tag_s;
    assign bus.issueOp     = instr_q[OP_LSB  +: OP_W];
    assign bus.issueRz     = instr_q[RZ_LSB  +: REG_IDX_W];
    assign bus.issueOffset = instr_q[OFF_LSB +: OFF_W];

endmodule

// File: tb/tb_issue_unit.sv
// Directed self-checking bench for issue_unit with hand-computed expectations.
module tb_issue_unit;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [2:0] rsAddFree;
    logic [1:0] rsMulFree;
    logic       cdbValid;
    logic [2:0] cdbTag;
    int         checks   = 0;
    int         failures = 0;

    issue_unit_if bus ();

    issue_unit dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .bus       (bus),
        .rsAddFree (rsAddFree),
        .rsMulFree (rsMulFree),
        .cdbValid  (cdbValid),
        .cdbTag    (cdbTag)
    );

    always #5 Clock = ~Clock;

    // Load one instruction; returns 2 time units into the HELD cycle.
    task automatic accept(input logic [15:0] ins);
        bus.enableIn      = 1'b1;
        bus.instructionIn = ins;
        @(posedge Clock);
        #1;
        bus.enableIn = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.enableIn = 1'b0; bus.instructionIn = 16'h0000;
        rsAddFree = 3'b111; rsMulFree = 2'b11; cdbValid = 1'b0; cdbTag = 3'd0;
        #3;
        checks++; if (bus.disponivel !== 1'b1) begin failures++; $display("FAIL rst_disp got=%0d exp=1", bus.disponivel); end
        checks++; if (bus.issueValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0d exp=0", bus.issueValid); end
        checks++; if ({bus.issueOp, bus.issueRz, bus.issueQj, bus.issueQk, bus.issueOffset} !== 16'h0000) begin
            failures++; $display("FAIL rst_fields got=%0h exp=0", {bus.issueOp, bus.issueRz, bus.issueQj, bus.issueQk, bus.issueOffset}); end
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    task automatic test_add();
        accept({3'd0, 3'd3, 3'd1, 3'd2, 4'b0000});
        checks++; if (bus.issueValid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0d exp=1", bus.issueValid); end
        checks++; if (bus.issueTag !== 3'd1) begin failures++; $display("FAIL add_tag got=%0d exp=1", bus.issueTag); end
        checks++; if (bus.issueOp !== 4'b0000 || bus.issueRz !== 3'd3) begin failures++; $display("FAIL add_oprz got=%0h/%0d exp=0/3", bus.issueOp, bus.issueRz); end
        checks++; if (bus.issueQj !== 3'd0 || bus.issueQk !== 3'd0) begin failures++; $display("FAIL add_q got=%0d/%0d exp=0/0", bus.issueQj, bus.issueQk); end
        checks++; if (bus.disponivel !== 1'b0) begin failures++; $display("FAIL add_disp got=%0d exp=0", bus.disponivel); end
        @(posedge Clock); #1;
        checks++; if (bus.disponivel !== 1'b1) begin failures++; $display("FAIL add_empty got=%0d exp=1", bus.disponivel); end
    endtask

    task automatic test_cdb_bypass();
        rsAddFree = 3'b110;
        accept({3'd0, 3'd5, 3'd3, 3'd1, 4'b0001});
        checks++; if (bus.issueQj !== 3'd1) begin failures++; $display("FAIL sub_qj_busy got=%0d exp=1", bus.issueQj); end
        checks++; if (bus.issueTag !== 3'd2) begin failures++; $display("FAIL sub_tag got=%0d exp=2", bus.issueTag); end
        cdbValid = 1'b1; cdbTag = 3'd1;
        #1;
        checks++; if (bus.issueQj !== 3'd0) begin failures++; $display("FAIL sub_qj_bypass got=%0d exp=0", bus.issueQj); end
        checks++; if (bus.issueQk !== 3'd0 || bus.issueValid !== 1'b1) begin failures++; $display("FAIL sub_qk_valid got=%0d/%0d exp=0/1", bus.issueQk, bus.issueValid); end
        @(posedge Clock); #1;
        cdbValid = 1'b0; cdbTag = 3'd0;
    endtask

    task automatic test_stall();
        rsMulFree = 2'b00;
        accept({3'd0, 3'd6, 3'd5, 3'd3, 4'b0100});
        bus.enableIn = 1'b1; bus.instructionIn = {3'd7, 3'd1, 3'd1, 3'd1, 4'b0000};
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.issueValid !== 1'b0 || bus.disponivel !== 1'b0) begin
                failures++; $display("FAIL stall_c%0d got=%0d/%0d exp=0/0", k, bus.issueValid, bus.disponivel); end
            if (k < 3) begin
                @(posedge Clock); #1;
            end
        end
        checks++; if (bus.issueRz !== 3'd6 || bus.issueOp !== 4'b0100) begin failures++; $display("FAIL stall_hold got=%0d/%0h exp=6/4", bus.issueRz, bus.issueOp); end
        bus.enableIn = 1'b0; rsMulFree = 2'b01;
        #1;
        checks++; if (bus.issueValid !== 1'b1 || bus.issueTag !== 3'd4) begin failures++; $display("FAIL mul_tag got=%0d/%0d exp=1/4", bus.issueValid, bus.issueTag); end
        checks++; if (bus.issueQj !== 3'd2 || bus.issueQk !== 3'd0) begin failures++; $display("FAIL mul_q got=%0d/%0d exp=2/0", bus.issueQj, bus.issueQk); end
        @(posedge Clock); #1;
        checks++; if (bus.disponivel !== 1'b1) begin failures++; $display("FAIL mul_empty got=%0d exp=1", bus.disponivel); end
    endtask

    task automatic test_write_priority();
        rsAddFree = 3'b001;
        accept({3'd0, 3'd6, 3'd6, 3'd0, 4'b0000});
        cdbValid = 1'b1; cdbTag = 3'd4;
        #1;
        checks++; if (bus.issueTag !== 3'd1 || bus.issueQj !== 3'd0) begin failures++; $display("FAIL prio_issue got=%0d/%0d exp=1/0", bus.issueTag, bus.issueQj); end
        @(posedge Clock); #1;
        cdbValid = 1'b0; cdbTag = 3'd0; rsAddFree = 3'b100;
        accept({3'd5, 3'd6, 3'd6, 3'd5, 4'b0000});
        checks++; if (bus.issueQj !== 3'd1) begin failures++; $display("FAIL prio_status6 got=%0d exp=1", bus.issueQj); end
        checks++; if (bus.issueQk !== 3'd2 || bus.issueTag !== 3'd3) begin failures++; $display("FAIL prio_qk_tag got=%0d/%0d exp=2/3", bus.issueQk, bus.issueTag); end
        checks++; if (bus.issueOffset !== 3'd5) begin failures++; $display("FAIL prio_offset got=%0d exp=5", bus.issueOffset); end
        @(posedge Clock); #1;
    endtask

    task automatic test_invalid_op();
        rsAddFree = 3'b111; rsMulFree = 2'b11;
        accept({3'd0, 3'd1, 3'd2, 3'd3, 4'b1111});
        checks++; if (bus.issueValid !== 1'b0 || bus.disponivel !== 1'b0) begin failures++; $display("FAIL bad_held got=%0d/%0d exp=0/0", bus.issueValid, bus.disponivel); end
        @(posedge Clock); #1;
        checks++; if (bus.disponivel !== 1'b1 || bus.issueValid !== 1'b0) begin failures++; $display("FAIL bad_drop got=%0d/%0d exp=1/0", bus.disponivel, bus.issueValid); end
    endtask

    task automatic test_reset_mid_held();
        rsMulFree = 2'b00;
        accept({3'd0, 3'd7, 3'd6, 3'd5, 4'b0100});
        checks++; if (bus.issueQj !== 3'd3 || bus.issueQk !== 3'd2) begin failures++; $display("FAIL mid_q got=%0d/%0d exp=3/2", bus.issueQj, bus.issueQk); end
        Reset = 1'b1;
        #1;
        checks++; if (bus.disponivel !== 1'b1 || bus.issueValid !== 1'b0) begin failures++; $display("FAIL mid_async got=%0d/%0d exp=1/0", bus.disponivel, bus.issueValid); end
        checks++; if (bus.issueQj !== 3'd0 || bus.issueQk !== 3'd0 || bus.issueRz !== 3'd0) begin
            failures++; $display("FAIL mid_clear got=%0d/%0d/%0d exp=0/0/0", bus.issueQj, bus.issueQk, bus.issueRz); end
        rsMulFree = 2'b11;
        #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
        checks++; if (bus.issueValid !== 1'b0 || bus.disponivel !== 1'b1) begin failures++; $display("FAIL mid_nodisp got=%0d/%0d exp=0/1", bus.issueValid, bus.disponivel); end
        accept({3'd0, 3'd1, 3'd6, 3'd5, 4'b0000});
        checks++; if (bus.issueTag !== 3'd1 || bus.issueQj !== 3'd0 || bus.issueQk !== 3'd0) begin
            failures++; $display("FAIL mid_after got=%0d/%0d/%0d exp=1/0/0", bus.issueTag, bus.issueQj, bus.issueQk); end
        @(posedge Clock); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_cdb_bypass();
        test_stall();
        test_write_priority();
        test_invalid_op();
        test_reset_mid_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
